// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared types, opcode encodings, mux-select encodings and
//               opcode-class helpers for the multicycle control FSM.
// Revision    : 1.0  initial release
// ============================================================================
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_STORE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  // Opcode encodings (6-bit opcode field)
  localparam logic [5:0] OP_MOV  = 6'h10;
  localparam logic [5:0] OP_ADD  = 6'h12;
  localparam logic [5:0] OP_SUB  = 6'h13;
  localparam logic [5:0] OP_OR   = 6'h14;
  localparam logic [5:0] OP_AND  = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_BNE  = 6'h21;
  localparam logic [5:0] OP_JMP  = 6'h22;
  localparam logic [5:0] OP_ADDI = 6'h32;
  localparam logic [5:0] OP_SUBI = 6'h33;
  localparam logic [5:0] OP_ORI  = 6'h34;
  localparam logic [5:0] OP_ANDI = 6'h35;
  localparam logic [5:0] OP_LI   = 6'h39;
  localparam logic [5:0] OP_LWI  = 6'h3B;
  localparam logic [5:0] OP_SWI  = 6'h3C;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // ALU B operand select
  localparam logic [1:0] ALUB_B    = 2'd0;
  localparam logic [1:0] ALUB_ONE  = 2'd1;
  localparam logic [1:0] ALUB_ZEXT = 2'd2;
  localparam logic [1:0] ALUB_SEXT = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OR)  || (op == OP_AND);
  endfunction

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_ORI) ||
           (op == OP_ANDI) || (op == OP_LI);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_rtype(op) || is_itype(op) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP) ||
           (op == OP_LWI) || (op == OP_SWI) || (op == OP_HALT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_sm_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_opcode_decode
// Description : Combinational opcode classification plus the ALU-B immediate
//               extension select used by DECODE and EXEC.
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_opcode_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output logic       is_rtype_o,
  output logic       is_itype_o,
  output logic       is_branch_o,
  output logic       is_jump_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_halt_o,
  output logic       is_legal_o,
  output logic [1:0] imm_sel_o
);

  // Classify the opcode and pick the immediate extension for EXEC
  always_comb begin
    is_rtype_o  = is_rtype(op_i);
    is_itype_o  = is_itype(op_i);
    is_branch_o = (op_i == OP_BEQ) || (op_i == OP_BNE);
    is_jump_o   = (op_i == OP_JMP);
    is_load_o   = (op_i == OP_LWI);
    is_store_o  = (op_i == OP_SWI);
    is_halt_o   = (op_i == OP_HALT);
    is_legal_o  = is_legal(op_i);
    // Arithmetic immediates are signed; logical immediates and LI are not
    if ((op_i == OP_ADDI) || (op_i == OP_SUBI))
      imm_sel_o = ALUB_SEXT;
    else if ((op_i == OP_ORI) || (op_i == OP_ANDI) || (op_i == OP_LI))
      imm_sel_o = ALUB_ZEXT;
    else
      imm_sel_o = ALUB_B;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_sm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_sm
// Description : Multicycle datapath control FSM with memory-ready stalls,
//               branch/jump/halt, illegal-opcode flag and retire counter.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl_sm
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W         = 6,
  parameter int CNT_W        = 16,
  parameter bit MEM_STALL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op_code,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             a_write,
  output logic             b_write,
  output logic             aluout_write,
  output logic             rf_write,
  output logic             iord_sel,
  output logic             rf_b_sel,
  output logic             wd_sel,
  output logic             alu_a_sel,
  output logic [1:0]       pc_src_sel,
  output logic [1:0]       alu_b_sel,
  output logic [OP_W-1:0]  alu_opcode,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(OP_ADD);

  state_t           state_q, state_d;
  logic             halted_q, illegal_q;
  logic [CNT_W-1:0] count_q;

  logic [5:0] op6;
  logic       ready;
  logic       dec_rtype, dec_itype, dec_branch, dec_jump;
  logic       dec_load, dec_store, dec_halt, dec_legal;
  logic [1:0] dec_imm_sel;
  logic       retire;

  // The encodings are 6-bit; narrower opcode buses are zero-extended
  generate
    if (OP_W >= 6) begin : g_op_wide
      assign op6 = op_code[5:0];
      if (OP_W > 6) begin : g_op_unused
        logic unused_hi;
        assign unused_hi = ^op_code[OP_W-1:6];
      end
    end else begin : g_op_narrow
      assign op6 = {{(6-OP_W){1'b0}}, op_code};
    end
  endgenerate

  // With stalls disabled every memory access completes immediately
  generate
    if (MEM_STALL_EN) begin : g_stall
      assign ready = mem_ready;
    end else begin : g_nostall
      logic unused_ready;
      assign unused_ready = mem_ready;
      assign ready        = 1'b1;
    end
  endgenerate

  ctrl_opcode_decode u_decode (
    .op_i        (op6),
    .is_rtype_o  (dec_rtype),
    .is_itype_o  (dec_itype),
    .is_branch_o (dec_branch),
    .is_jump_o   (dec_jump),
    .is_load_o   (dec_load),
    .is_store_o  (dec_store),
    .is_halt_o   (dec_halt),
    .is_legal_o  (dec_legal),
    .imm_sel_o   (dec_imm_sel)
  );

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:     if (ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_halt)                    state_d = S_HALT;
        else if (dec_rtype || dec_itype) state_d = S_EXEC;
        else if (dec_branch)             state_d = S_BRANCH;
        else if (dec_jump)               state_d = S_JUMP;
        else if (dec_load || dec_store)  state_d = S_MEM_ADDR;
        else                             state_d = S_FETCH;
      end
      S_MEM_ADDR:  state_d = dec_load ? S_MEM_READ : S_MEM_STORE;
      S_MEM_READ:  if (ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_STORE: if (ready) state_d = S_FETCH;
      S_EXEC:      state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that returns the FSM to FETCH
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_STORE: retire = ready;
      S_DECODE:    retire = !dec_legal;
      default:     retire = 1'b0;
    endcase
  end

  // State register and status flags; everything freezes while start is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (start) begin
      state_q <= state_d;
      if (state_q == S_DECODE && dec_halt)
        halted_q <= 1'b1;
      if (state_q == S_DECODE && !dec_legal)
        illegal_q <= 1'b1;
      if (retire)
        count_q <= count_q + 1'b1;
    end
  end

  // Datapath enables and selects, decoded from state and opcode
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    a_write       = 1'b0;
    b_write       = 1'b0;
    aluout_write  = 1'b0;
    rf_write      = 1'b0;
    iord_sel      = 1'b0;
    rf_b_sel      = 1'b0;
    wd_sel        = 1'b0;
    alu_a_sel     = 1'b0;
    pc_src_sel    = PCSRC_ALU;
    alu_b_sel     = ALUB_B;
    alu_opcode    = op_code;
    if (start && !reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_a_sel  = 1'b1;
          alu_b_sel  = ALUB_ONE;
          alu_opcode = ALU_ADD;
          ir_write   = ready;
          pc_write   = ready;
        end
        S_DECODE: begin
          a_write      = 1'b1;
          b_write      = 1'b1;
          aluout_write = 1'b1;
          alu_a_sel    = 1'b1;
          alu_b_sel    = ALUB_SEXT;
          alu_opcode   = ALU_ADD;
          rf_b_sel     = op6[5];
        end
        S_MEM_ADDR: begin
          alu_b_sel    = ALUB_SEXT;
          aluout_write = 1'b1;
          alu_opcode   = ALU_ADD;
        end
        S_MEM_READ: begin
          mem_req   = 1'b1;
          iord_sel  = 1'b1;
          mdr_write = ready;
        end
        S_MEM_WB: begin
          wd_sel   = 1'b1;
          rf_write = 1'b1;
        end
        S_MEM_STORE: begin
          mem_req   = 1'b1;
          iord_sel  = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          aluout_write = 1'b1;
          alu_b_sel    = dec_imm_sel;
        end
        S_ALU_WB:    rf_write = 1'b1;
        S_BRANCH: begin
          pc_write_cond = 1'b1;
          pc_src_sel    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src_sel = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign halted        = halted_q;
  assign illegal_op    = illegal_q;
  assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_sm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_sm
// Description : Directed self-checking bench for multicycle_ctrl_sm.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl_sm;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready;
  logic [5:0]  op_code;
  logic        mem_req, mem_write, pc_write, pc_write_cond, ir_write, mdr_write;
  logic        a_write, b_write, aluout_write, rf_write;
  logic        iord_sel, rf_b_sel, wd_sel, alu_a_sel;
  logic [1:0]  pc_src_sel, alu_b_sel;
  logic [5:0]  alu_opcode;
  logic        halted, illegal_op;
  logic [15:0] retired_count;

  int checks   = 0;
  int failures = 0;

  // Control bits packed for whole-vector comparison
  logic [17:0] ctl;
  assign ctl = {mem_req, mem_write, pc_write, pc_write_cond, ir_write, mdr_write,
                a_write, b_write, aluout_write, rf_write, iord_sel, rf_b_sel,
                wd_sel, alu_a_sel, pc_src_sel, alu_b_sel};

  localparam logic [17:0] MREQ = 18'h20000, MWR = 18'h10000, PCW = 18'h08000;
  localparam logic [17:0] PCWC = 18'h04000, IRW = 18'h02000, MDRW = 18'h01000;
  localparam logic [17:0] AW   = 18'h00800, BW  = 18'h00400, AOW  = 18'h00200;
  localparam logic [17:0] RFW  = 18'h00100, IORD = 18'h00080, RFB = 18'h00040;
  localparam logic [17:0] WDS  = 18'h00020, ALUA = 18'h00010;
  localparam logic [17:0] PCS1 = 18'h00004, PCS2 = 18'h00008;
  localparam logic [17:0] ALB1 = 18'h00001, ALB2 = 18'h00002, ALB3 = 18'h00003;

  localparam logic [17:0] E_FETCH  = MREQ | IRW | PCW | ALUA | ALB1;
  localparam logic [17:0] E_FSTALL = MREQ | ALUA | ALB1;
  localparam logic [17:0] E_DEC    = AW | BW | AOW | ALUA | ALB3;

  multicycle_ctrl_sm #(.OP_W(6), .CNT_W(16), .MEM_STALL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op_code(op_code),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mdr_write(mdr_write), .a_write(a_write), .b_write(b_write),
    .aluout_write(aluout_write), .rf_write(rf_write), .iord_sel(iord_sel),
    .rf_b_sel(rf_b_sel), .wd_sel(wd_sel), .alu_a_sel(alu_a_sel),
    .pc_src_sel(pc_src_sel), .alu_b_sel(alu_b_sel), .alu_opcode(alu_opcode),
    .halted(halted), .illegal_op(illegal_op), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-cycle
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; mem_ready = 1'b1; op_code = 6'h12;
    #2;
    chk("reset_no_enables", 32'(ctl), 32'h0);
    chk("reset_aluop_passthru", 32'(alu_opcode), 32'h12);
    nxt();
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_illegal", 32'(illegal_op), 32'h0);
    chk("reset_count", 32'(retired_count), 32'h0);
    reset = 1'b0; #1;

    // ADD: FETCH, DECODE, EXEC, ALU_WB
    chk("add_fetch", 32'(ctl), 32'(E_FETCH));
    chk("add_fetch_aluop", 32'(alu_opcode), 32'h12);
    nxt(); chk("add_decode", 32'(ctl), 32'(E_DEC));
    nxt(); chk("add_exec", 32'(ctl), 32'(AOW));
    chk("add_exec_aluop", 32'(alu_opcode), 32'h12);
    nxt(); chk("add_aluwb", 32'(ctl), 32'(RFW));
    chk("add_count_before", 32'(retired_count), 32'h0);
    nxt(); chk("add_count_after", 32'(retired_count), 32'h1);

    // FETCH stall, then LWI with a 3-cycle MEM_READ stall
    op_code = 6'h3B; mem_ready = 1'b0; #1;
    chk("fetch_stall", 32'(ctl), 32'(E_FSTALL));
    nxt(); chk("fetch_stall_hold", 32'(ctl), 32'(E_FSTALL));
    mem_ready = 1'b1; #1;
    chk("lwi_fetch", 32'(ctl), 32'(E_FETCH));
    nxt(); chk("lwi_decode", 32'(ctl), 32'(E_DEC | RFB));
    nxt(); chk("lwi_memaddr", 32'(ctl), 32'(AOW | ALB3));
    nxt(); mem_ready = 1'b0; #1;
    chk("lwi_memread_w1", 32'(ctl), 32'(MREQ | IORD));
    nxt(); chk("lwi_memread_w2", 32'(ctl), 32'(MREQ | IORD));
    nxt(); chk("lwi_memread_w3", 32'(ctl), 32'(MREQ | IORD));
    nxt(); mem_ready = 1'b1; #1;
    chk("lwi_memread_rdy", 32'(ctl), 32'(MREQ | IORD | MDRW));
    nxt(); chk("lwi_memwb", 32'(ctl), 32'(WDS | RFW));
    nxt(); chk("lwi_count", 32'(retired_count), 32'h2);

    // ADDI: sign-extended immediate; mem_ready toggling outside memory states
    op_code = 6'h32; #1;
    nxt(); mem_ready = 1'b0; #1;
    chk("addi_decode_ready_ignored", 32'(ctl), 32'(E_DEC | RFB));
    nxt(); chk("addi_exec", 32'(ctl), 32'(AOW | ALB3));
    chk("addi_exec_aluop", 32'(alu_opcode), 32'h32);
    nxt(); chk("addi_aluwb", 32'(ctl), 32'(RFW));
    nxt(); mem_ready = 1'b1; #1;
    chk("addi_count", 32'(retired_count), 32'h3);

    // ORI: zero-extended immediate
    op_code = 6'h34; #1;
    nxt(); nxt(); chk("ori_exec", 32'(ctl), 32'(AOW | ALB2));
    nxt(); nxt(); chk("ori_count", 32'(retired_count), 32'h4);

    // BNE
    op_code = 6'h21; #1;
    nxt(); nxt(); chk("bne_branch", 32'(ctl), 32'(PCWC | PCS1));
    chk("bne_aluop", 32'(alu_opcode), 32'h21);
    nxt(); chk("bne_count", 32'(retired_count), 32'h5);

    // JMP
    op_code = 6'h22; #1;
    nxt(); nxt(); chk("jmp_jump", 32'(ctl), 32'(PCW | PCS2));
    nxt(); chk("jmp_count", 32'(retired_count), 32'h6);

    // Illegal opcode 07
    op_code = 6'h07; #1;
    nxt(); chk("illegal_decode", 32'(ctl), 32'(E_DEC));
    chk("illegal_flag_before", 32'(illegal_op), 32'h0);
    nxt(); chk("illegal_flag_after", 32'(illegal_op), 32'h1);
    chk("illegal_back_to_fetch", 32'(ctl), 32'(E_FETCH));
    chk("illegal_count", 32'(retired_count), 32'h7);

    // start=0 for five cycles mid-EXEC
    op_code = 6'h12; #1;
    nxt(); nxt(); chk("pause_exec_before", 32'(ctl), 32'(AOW));
    start = 1'b0; #1;
    chk("pause_no_enables", 32'(ctl), 32'h0);
    for (int i = 0; i < 5; i++) begin
      nxt(); chk("pause_hold", 32'(ctl), 32'h0);
    end
    start = 1'b1; #1;
    chk("pause_resume_exec", 32'(ctl), 32'(AOW));
    nxt(); chk("pause_resume_aluwb", 32'(ctl), 32'(RFW));
    nxt(); chk("pause_count", 32'(retired_count), 32'h8);

    // SWI: stall, drop start mid-stall, then reset mid-store
    op_code = 6'h3C; #1;
    nxt(); nxt(); nxt(); mem_ready = 1'b0; #1;
    chk("swi_store", 32'(ctl), 32'(MREQ | MWR | IORD));
    start = 1'b0; #1;
    chk("swi_start_low_memreq", 32'(ctl), 32'h0);
    nxt(); start = 1'b1; #1;
    chk("swi_store_held", 32'(ctl), 32'(MREQ | MWR | IORD));
    reset = 1'b1; #1;
    chk("swi_reset_no_write", 32'(ctl), 32'h0);
    nxt(); reset = 1'b0; #1;
    chk("swi_reset_fetch", 32'(ctl), 32'(E_FSTALL));
    chk("swi_reset_count", 32'(retired_count), 32'h0);
    chk("swi_reset_illegal", 32'(illegal_op), 32'h0);

    // HALT
    op_code = 6'h3F; mem_ready = 1'b1; #1;
    nxt(); nxt();
    chk("halt_flag", 32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      chk("halt_no_enables", 32'(ctl), 32'h0);
      nxt();
    end
    chk("halt_count", 32'(retired_count), 32'h0);
    reset = 1'b1;
    nxt(); reset = 1'b0; #1;
    chk("halt_reset_clears", 32'(halted), 32'h0);
    chk("halt_reset_fetch", 32'(ctl), 32'(E_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_sm.md
Name: multicycle_ctrl_sm

Overview:
- Parametrised successor to the lab multicycle control FSM. Sequences the shared-bus datapath (PC, IR, MDR, A/B, ALU-out registers, register file, unified memory) through fetch/decode/execute states.
- Adds a memory-ready stall handshake, BNE/JMP/HALT opcodes, and an illegal-opcode flag.
- Adds correct sign- versus zero-extended immediate selection and a retired-instruction counter.
- Sits between the instruction register opcode field and all datapath enables/mux selects.

Parameters:
- OP_W, 6, opcode and ALU opcode width; opcode encodings below are fixed for OP_W=6.
- CNT_W, 16, width of the retired-instruction counter.
- MEM_STALL_EN, 1; if 0, mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  run enable; 0 freezes state and forces every enable/select low.
- op_code  in  OP_W  IR opcode field.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access active (FETCH, MEM_READ, MEM_STORE).
- mem_write  out  1  memory write strobe.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load on the branch-compare result.
- ir_write, mdr_write, a_write, b_write, aluout_write, rf_write  out  1 each  register enables.
- iord_sel, rf_b_sel, wd_sel, alu_a_sel  out  1 each  mux selects.
- pc_src_sel  out  2  PC source select: 0 ALU, 1 ALU-out, 2 jump target.
- alu_b_sel  out  2  ALU B select: 0 B, 1 const 1, 2 zero-extended imm, 3 sign-extended imm.
- alu_opcode  out  OP_W  ALU operation.
- halted  out  1  HALT reached.
- illegal_op  out  1  sticky flag: unknown opcode decoded.
- retired_count  out  CNT_W  instructions completed.

Behaviour:
- Opcodes:
  - R-type: MOV 10, ADD 12, SUB 13, OR 14, AND 15.
  - Branch/jump: BEQ 20, BNE 21, JMP 22.
  - I-type: ADDI 32, SUBI 33, ORI 34, ANDI 35, LI 39.
  - Memory: LWI 3B, SWI 3C.
  - HALT 3F.
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_STORE, EXEC, ALU_WB, BRANCH, JUMP, HALT.
- State register advances only when start=1. Outputs are combinational (Moore on state plus op_code).
- Gating of outputs:
  - When start=0 or reset=1, every enable/select is 0 and alu_opcode = op_code.
  - halted, illegal_op and retired_count always reflect their registers.
- Reset:
  - state is FETCH, halted=0, illegal_op=0, retired_count=0.
  - While reset=1, no enable may be asserted.
- FETCH:
  - mem_req=1, alu_a_sel=1, alu_b_sel=1, alu_opcode=ADD.
  - ir_write and pc_write assert only when mem_ready=1; the transition to DECODE occurs on that cycle.
  - Otherwise stay in FETCH with no register write.
- DECODE:
  - a_write=b_write=aluout_write=1, alu_a_sel=1, alu_b_sel=3, alu_opcode=ADD (branch target).
  - rf_b_sel = op_code[5].
- Next state from DECODE:
  - R-type and I-type go to EXEC.
  - BEQ/BNE go to BRANCH; JMP goes to JUMP.
  - LWI/SWI go to MEM_ADDR; HALT goes to HALT.
  - Any other opcode: set illegal_op and go to FETCH, counted as retired.
- MEM_ADDR: alu_b_sel=3, aluout_write=1. LWI goes to MEM_READ; SWI goes to MEM_STORE.
- MEM_READ: mem_req=1, iord_sel=1. mdr_write asserts and the FSM goes to MEM_WB only when mem_ready=1; otherwise hold.
- MEM_WB: wd_sel=1, rf_write=1, then FETCH.
- MEM_STORE: mem_req=1, iord_sel=1, mem_write held high until mem_ready=1, then FETCH.
- EXEC:
  - aluout_write=1.
  - alu_b_sel: 3 for ADDI/SUBI, 2 for ORI/ANDI/LI, 0 for R-type.
  - alu_opcode = op_code.
  - Next state ALU_WB.
- ALU_WB: rf_write=1, then FETCH.
- BRANCH:
  - alu_opcode = op_code (20 or 21; the ALU produces the condition).
  - pc_write_cond=1, pc_src_sel=1, then FETCH.
- JUMP: pc_write=1, pc_src_sel=2, then FETCH.
- HALT: halted=1. The FSM stays in HALT until reset, asserts no enables, and does not increment the counter.
- retired_count increments by 1 (wrapping at 2^CNT_W) on the cycle the FSM leaves any of these for FETCH with start=1: MEM_WB, MEM_STORE, ALU_WB, BRANCH, JUMP, or DECODE on an illegal opcode.
- Boundary conditions:
  - start dropping mid-stall holds state, and mem_req goes low.
  - Reset mid-instruction returns the FSM to FETCH on the next edge, with no write on the reset cycle.
  - mem_ready outside a memory state is ignored.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state enum.
  - opcode constants.
  - alu_b_sel and pc_src_sel encodings.
  - is_rtype/is_itype/is_legal decode functions.
- One sub-module, ctrl_opcode_decode: combinational opcode classification and immediate-extension select, shared by the DECODE and EXEC logic.

Test Plan:
- ADD (op 12), mem_ready=1 throughout -> states FETCH, DECODE, EXEC, ALU_WB; rf_write only in cycle 4; retired_count 0 to 1.
- LWI (3B), mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mdr_write=0 until the ready cycle; total 8 cycles.
- ADDI (32) and ORI (34) in EXEC -> alu_b_sel=3 and 2 respectively.
- BNE (21) -> BRANCH asserts pc_write_cond=1, pc_src_sel=1, alu_opcode=21. JMP (22) -> pc_write=1, pc_src_sel=2.
- Opcode 07 -> illegal_op=1 after DECODE, FETCH next, count+1. HALT (3F) -> halted=1, no enables for 20 cycles; reset clears all.
- Assert reset during MEM_STORE with mem_ready=0 -> mem_write=0 on the reset cycle, state FETCH, count=0. start=0 for 5 cycles mid-EXEC -> all enables 0, state resumes unchanged.
